// File: rtl/ultrasonic_ranger_pkg.sv
// Shared FSM encodings, default timing constants and small helpers for the
// multi-channel ultrasonic ranging engine.
package ultrasonic_ranger_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIG      = 3'd1;
    localparam logic [2:0] ST_WAIT_RISE = 3'd2;
    localparam logic [2:0] ST_MEASURE   = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    // 50 MHz defaults: 10 us trigger, 30 ms echo limit, 60 ms dead time.
    localparam int DEF_N_CH         = 2;
    localparam int DEF_CNT_W        = 24;
    localparam int DEF_TRIG_CYCLES  = 500;
    localparam int DEF_ECHO_TIMEOUT = 1_500_000;
    localparam int DEF_GAP_CYCLES   = 3_000_000;
    localparam int DEF_NEAR_ON      = 29_000;
    localparam int DEF_NEAR_OFF     = 35_000;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Two-flop synchronizer for one raw echo line, plus an edge-detect register
// producing single-cycle rise and fall pulses.
module ultrasonic_ranger_echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_echo,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_echo;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/ultrasonic_ranger.sv
// Round-robin HC-SR04 ranging engine: triggers each sensor in turn, times its
// echo with one shared counter and publishes distance, timeout and near flags.
module ultrasonic_ranger
    import ultrasonic_ranger_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int TRIG_CYCLES  = DEF_TRIG_CYCLES,
    parameter int ECHO_TIMEOUT = DEF_ECHO_TIMEOUT,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int NEAR_ON      = DEF_NEAR_ON,
    parameter int NEAR_OFF     = DEF_NEAR_OFF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic                              cont_i,
    input  logic [N_CH-1:0]                   echo_i,
    output logic [N_CH-1:0]                   trigger_o,
    output logic [N_CH*CNT_W-1:0]             dist_o,
    output logic [N_CH-1:0]                   timeout_o,
    output logic [N_CH-1:0]                   near_o,
    output logic                              valid_o,
    output logic [clog2_min1(N_CH)-1:0]       ch_o,
    output logic                              busy_o
);

    localparam int CH_W = clog2_min1(N_CH);

    localparam logic [CNT_W-1:0] P_TRIG_LAST = CNT_W'((TRIG_CYCLES > 1) ? TRIG_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] P_GAP_LAST  = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] P_TIMEOUT   = CNT_W'(ECHO_TIMEOUT);
    localparam logic [CNT_W-1:0] P_NEAR_ON   = CNT_W'(NEAR_ON);
    localparam logic [CNT_W-1:0] P_NEAR_OFF  = CNT_W'(NEAR_OFF);
    localparam logic [CH_W-1:0]  P_LAST_CH   = CH_W'(N_CH - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] k);
        return N_CH'(1) << k;
    endfunction

    logic [2:0]        r_state;
    logic [CH_W-1:0]   r_ch;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_CH-1:0]   r_trig;
    logic              r_valid;

    logic              w_echo_sel;
    logic              w_rise;
    logic              w_fall;
    logic              w_commit;
    logic              w_timed_out;
    logic [CNT_W-1:0]  w_result;
    logic [CH_W-1:0]   w_ch_next;

    // Only one sensor is ever pinged, so a single synchronizer follows the mux.
    assign w_echo_sel = echo_i[r_ch];

    ultrasonic_ranger_echo_sync u_echo_sync (
        .clk    (clk),
        .rst    (rst),
        .i_echo (w_echo_sel),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_ch_next = (r_ch == P_LAST_CH) ? '0 : r_ch + CH_W'(1);

    always_comb begin
        w_commit    = 1'b0;
        w_timed_out = 1'b0;
        case (r_state)
            ST_WAIT_RISE: begin
                if (!w_rise && (r_cnt >= P_TIMEOUT)) begin
                    w_commit    = 1'b1;
                    w_timed_out = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (w_fall) begin
                    w_commit = 1'b1;
                end else if (r_cnt >= P_TIMEOUT) begin
                    w_commit    = 1'b1;
                    w_timed_out = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_result = w_timed_out ? {CNT_W{1'b1}} : r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_trig  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_commit;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (start_i || cont_i) begin
                        r_state <= ST_TRIG;
                        r_trig  <= onehot(r_ch);
                    end
                end
                ST_TRIG: begin
                    if (r_cnt >= P_TRIG_LAST) begin
                        r_trig  <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_RISE;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                ST_WAIT_RISE: begin
                    // The rise cycle is already the first high sample.
                    if (w_rise) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= ST_MEASURE;
                    end else if (w_commit) begin
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                ST_MEASURE: begin
                    if (w_commit) begin
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                ST_GAP: begin
                    if (r_cnt >= P_GAP_LAST) begin
                        r_cnt <= '0;
                        r_ch  <= w_ch_next;
                        if ((r_ch != P_LAST_CH) || cont_i) begin
                            r_state <= ST_TRIG;
                            r_trig  <= onehot(w_ch_next);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_trig  <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_dist;
            logic             r_timeout;
            logic             r_near;
            logic             w_hit;

            assign w_hit = w_commit && (r_ch == CH_W'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dist    <= '0;
                    r_timeout <= 1'b0;
                    r_near    <= 1'b0;
                end else if (w_hit) begin
                    r_dist    <= w_result;
                    r_timeout <= w_timed_out;
                    // Between the two thresholds the previous flag is kept.
                    if (w_timed_out) begin
                        r_near <= 1'b0;
                    end else if (w_result < P_NEAR_ON) begin
                        r_near <= 1'b1;
                    end else if (w_result > P_NEAR_OFF) begin
                        r_near <= 1'b0;
                    end
                end
            end

            assign dist_o[gi*CNT_W +: CNT_W] = r_dist;
            assign timeout_o[gi]             = r_timeout;
            assign near_o[gi]                = r_near;
        end
    endgenerate

    assign trigger_o = r_trig;
    assign valid_o   = r_valid;
    assign ch_o      = r_ch;
    assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench: a sensor model answers each trigger from a per-channel
// stimulus queue while a scoreboard checks every valid_o result in order.
module tb_ultrasonic_ranger;

    localparam int N_CH     = 2;
    localparam int CNT_W    = 24;
    localparam int TRIG     = 4;
    localparam int TMO      = 100;
    localparam int GAP      = 10;
    localparam int NEAR_ON  = 20;
    localparam int NEAR_OFF = 30;
    localparam int NV       = 16;

    typedef struct {
        int grp;
        int ch;
        int width;
        bit exp_to;
        bit exp_near;
        int lat;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start_i = 1'b0;
    logic                   cont_i = 1'b0;
    logic [N_CH-1:0]        echo_i;
    logic [N_CH-1:0]        echo_resp = '0;
    logic [N_CH-1:0]        echo_force = '0;
    logic [N_CH-1:0]        trigger_o;
    logic [N_CH*CNT_W-1:0]  dist_o;
    logic [N_CH-1:0]        timeout_o;
    logic [N_CH-1:0]        near_o;
    logic                   valid_o;
    logic [0:0]             ch_o;
    logic                   busy_o;

    assign echo_i = echo_resp | echo_force;

    ultrasonic_ranger #(
        .N_CH(N_CH), .CNT_W(CNT_W), .TRIG_CYCLES(TRIG), .ECHO_TIMEOUT(TMO),
        .GAP_CYCLES(GAP), .NEAR_ON(NEAR_ON), .NEAR_OFF(NEAR_OFF)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .cont_i(cont_i), .echo_i(echo_i),
        .trigger_o(trigger_o), .dist_o(dist_o), .timeout_o(timeout_o), .near_o(near_o),
        .valid_o(valid_o), .ch_o(ch_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_valid  = 0;
    int   cyc      = 0;
    int   fall_cyc [2];
    int   q0 [$];
    int   q1 [$];
    vec_t sb_q [$];
    vec_t vecs [NV];

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sensor model: after a trigger falls, wait a short flight time then hold
    // echo high for the queued width. Width <= 0 means the sensor stays silent.
    initial begin
        logic [1:0] prev;
        int         w;
        int         kk;
        bit         got;
        prev = '0;
        forever begin
            @(negedge clk);
            got = 1'b0;
            kk  = 0;
            for (int k = 0; k < 2; k++) begin
                if (prev[k] && !trigger_o[k]) begin
                    fall_cyc[k] = cyc;
                    got = 1'b1;
                    kk  = k;
                end
            end
            prev = trigger_o;
            if (got) begin
                w = 0;
                if (kk == 0 && q0.size() > 0) w = q0.pop_front();
                if (kk == 1 && q1.size() > 0) w = q1.pop_front();
                if (w > 0) begin
                    repeat (5 + 3 * kk) @(negedge clk);
                    echo_resp[kk] = 1'b1;
                    repeat (w) @(negedge clk);
                    echo_resp[kk] = 1'b0;
                    prev = trigger_o;
                end
            end
        end
    end

    // Scoreboard: every valid_o strobe pops the next expected result.
    initial begin
        vec_t   e;
        longint d;
        int     lat;
        forever begin
            @(negedge clk);
            if (valid_o) begin
                n_valid++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: ch_o=%0d, no result expected", ch_o);
                end else begin
                    e = sb_q.pop_front();
                    d = dist_o[e.ch*CNT_W +: CNT_W];
                    chk($sformatf("ch_o[w=%0d]", e.width), ch_o, e.ch);
                    chk($sformatf("timeout_ch%0d[w=%0d]", e.ch, e.width), timeout_o[e.ch], e.exp_to);
                    chk($sformatf("near_ch%0d[w=%0d]", e.ch, e.width), near_o[e.ch], e.exp_near);
                    if (e.exp_to) begin
                        chk($sformatf("dist_ch%0d_allones", e.ch), d, 64'hFF_FFFF);
                    end else begin
                        n_checks++;
                        if (d < e.width - 1 || d > e.width + 1) begin
                            n_fail++;
                            $display("FAIL dist_ch%0d: got %0d, expected %0d+-1", e.ch, d, e.width);
                        end
                    end
                    if (e.lat > 0) begin
                        lat = cyc - fall_cyc[e.ch];
                        n_checks++;
                        if (lat < e.lat - 2 || lat > e.lat + 3) begin
                            n_fail++;
                            $display("FAIL timeout_latency_ch%0d: got %0d cycles, expected about %0d", e.ch, lat, e.lat);
                        end
                    end
                end
            end
        end
    end

    task automatic load_group(input int g);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].grp == g) begin
                if (vecs[i].ch == 0) q0.push_back(vecs[i].width);
                else                 q1.push_back(vecs[i].width);
                sb_q.push_back(vecs[i]);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && busy_o; i++) @(negedge clk);
        n_checks++;
        if (busy_o) begin
            n_fail++;
            $display("FAIL %s_idle: busy_o still 1 after %0d cycles, expected 0", tag, budget);
        end
    endtask

    task automatic wait_cond_valid(input int target, input int budget);
        for (int i = 0; i < budget && n_valid < target; i++) @(negedge clk);
        n_checks++;
        if (n_valid < target) begin
            n_fail++;
            $display("FAIL wait_valid: got %0d strobes, expected %0d", n_valid, target);
        end
    endtask

    task automatic wait_trig0(input int budget, input string tag);
        for (int i = 0; i < budget && !trigger_o[0]; i++) @(negedge clk);
        n_checks++;
        if (!trigger_o[0]) begin
            n_fail++;
            $display("FAIL %s_trigger: trigger_o=%b, expected bit0 high", tag, trigger_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        //          grp ch width to near lat
        vecs[0]  = '{0, 0, 15, 1'b0, 1'b1, 0};
        vecs[1]  = '{0, 1, 40, 1'b0, 1'b0, 0};
        vecs[2]  = '{1, 0, 25, 1'b0, 1'b1, 0};
        vecs[3]  = '{1, 1,  0, 1'b1, 1'b0, 100};
        vecs[4]  = '{2, 0, -1, 1'b1, 1'b0, 100};
        vecs[5]  = '{2, 1, 150, 1'b1, 1'b0, 0};
        vecs[6]  = '{3, 0, 15, 1'b0, 1'b1, 0};
        vecs[7]  = '{3, 1, 12, 1'b0, 1'b1, 0};
        vecs[8]  = '{3, 0, 25, 1'b0, 1'b1, 0};
        vecs[9]  = '{3, 1, 28, 1'b0, 1'b1, 0};
        vecs[10] = '{3, 0, 35, 1'b0, 1'b0, 0};
        vecs[11] = '{3, 1, 33, 1'b0, 1'b0, 0};
        vecs[12] = '{3, 0, 25, 1'b0, 1'b0, 0};
        vecs[13] = '{3, 1, 22, 1'b0, 1'b0, 0};
        vecs[14] = '{4, 0, 15, 1'b0, 1'b1, 0};
        vecs[15] = '{4, 1, 40, 1'b0, 1'b0, 0};

        repeat (3) @(negedge clk);
        chk("reset_trigger", trigger_o, 0);
        chk("reset_dist", dist_o, 0);
        chk("reset_timeout", timeout_o, 0);
        chk("reset_near", near_o, 0);
        chk("reset_valid", valid_o, 0);
        chk("reset_ch", ch_o, 0);
        chk("reset_busy", busy_o, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single shot with extra start pulses while busy.
        load_group(0);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            repeat (15) @(negedge clk);
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        wait_idle(2000, "g0");
        repeat (100) @(negedge clk);
        chk("g0_valid_count", n_valid, 2);
        chk("g0_busy_after", busy_o, 0);
        chk("g0_near_vector", near_o, 2'b01);

        // ch1 silent: timeout from WAIT_RISE.
        load_group(1);
        pulse_start();
        wait_idle(2000, "g1");
        chk("g1_valid_count", n_valid, 4);

        // ch0 stuck high before trigger, ch1 echo longer than the limit.
        echo_force[0] = 1'b1;
        repeat (20) @(negedge clk);
        load_group(2);
        pulse_start();
        wait_idle(2000, "g2");
        echo_force[0] = 1'b0;
        repeat (80) @(negedge clk);
        chk("g2_valid_count", n_valid, 6);

        // Continuous hysteresis sweeps; cont_i dropped during ch0 of the 4th.
        load_group(3);
        @(negedge clk);
        cont_i = 1'b1;
        wait_cond_valid(12, 3000);
        wait_trig0(200, "g3");
        cont_i = 1'b0;
        wait_idle(2000, "g3");
        repeat (100) @(negedge clk);
        chk("g3_valid_count", n_valid, 14);
        chk("g3_busy_after", busy_o, 0);

        // Asynchronous reset in the middle of a trigger pulse.
        pulse_start();
        wait_trig0(50, "rst");
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_trigger_drop", trigger_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_dist", dist_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_near", near_o, 0);
        chk("rst_valid", valid_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_trigger", trigger_o, 0);
        chk("post_rst_valid_count", n_valid, 14);

        // Fresh sweep after reset.
        load_group(4);
        pulse_start();
        wait_idle(2000, "g4");
        repeat (20) @(negedge clk);
        chk("g4_valid_count", n_valid, 16);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
